// File: rtl/config_pkg.sv
// Shared UART configuration: receiver state encoding, default line settings
// and the elaboration-time baud divisor calculation.
package config_pkg;

  localparam int unsigned BaudRateDefault   = 115200;
  localparam int unsigned OversampleDefault = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int unsigned baud_divisor(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned os);
    longint unsigned den;
    den = baud * os;
    return 32'((clk_hz + den / 64'd2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample-tick prescaler: one-cycle tick per Divisor clocks, synchronous clear
// parks the count at zero so the tick phase follows the release of clr_i.
module uart_baud_gen #(
  parameter int unsigned Divisor = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Divisor > 1) ? $clog2(Divisor) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(Divisor - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1-style UART receiver with 3-sample majority vote, ready/valid
// byte output, framing-error and overrun pulses.
module uart_rx_os
  import config_pkg::*;
#(
  parameter int unsigned ClkFreqHz  = 100_000_000,
  parameter int unsigned BaudRate   = BaudRateDefault,
  parameter int unsigned Oversample = OversampleDefault,
  parameter int unsigned DataWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned Divisor = baud_divisor(64'(ClkFreqHz), 64'(BaudRate),
                                                 64'(Oversample));
  localparam int unsigned TickW   = $clog2(Oversample);
  localparam int unsigned BitW    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam int unsigned SampA   = Oversample / 2 - 1;
  localparam int unsigned SampB   = Oversample / 2;
  localparam int unsigned SampC   = Oversample / 2 + 1;

  uart_rx_state_e       state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, baud_clr, majority, decide, done;

  // Prescaler idles at zero so the first tick is timed from the start edge.
  assign baud_clr = (state_q == IDLE) || (state_q == WAIT_IDLE);

  uart_baud_gen #(
    .Divisor(Divisor)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  assign majority = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign decide   = tick && (tick_cnt_q == TickW'(SampC));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    done       = 1'b0;

    if (valid_q && ready_i) valid_d = 1'b0;

    if (tick) begin
      tick_cnt_d = (tick_cnt_q == TickW'(Oversample - 1)) ? '0 : tick_cnt_q + TickW'(1);
      if (tick_cnt_q == TickW'(SampA)) s0_d = rx_sync_q;
      if (tick_cnt_q == TickW'(SampB)) s1_d = rx_sync_q;
    end

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        if (decide) state_d = majority ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_d   = {majority, shift_q[DataWidth-1:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitW'(DataWidth - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Decided mid stop bit so the next start edge is never missed.
        if (decide) begin
          if (majority) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        tick_cnt_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os; the line rate is raised (divisor 8) so the
// whole directed sequence stays short, with the same 100 MHz core clock.
module tb_uart_rx_os;

  localparam int unsigned BaudRate = 781_250;
  localparam real         BitNs    = 1280.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, ovr;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rx_cnt   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_rx_os #(
    .ClkFreqHz (100_000_000),
    .BaudRate  (BaudRate),
    .Oversample(16),
    .DataWidth (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(ferr),
    .overrun_o  (ovr)
  );

  always #5ns clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted byte, tallies error pulses.
  always @(negedge clk) begin
    if (valid && ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
      end else begin
        check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
      end
    end
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
  end

  task automatic idle_bits(input real n);
    rx = 1'b1;
    #(n * BitNs * 1ns);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns,
                            input int glitch_bit);
    rx = 1'b0;
    #(bit_ns * 1ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == glitch_bit) begin
        // Two-cycle flip over the middle majority sample.
        #730ns;
        rx = ~b[i];
        #20ns;
        rx = b[i];
        #((bit_ns - 750.0) * 1ns);
      end else begin
        #(bit_ns * 1ns);
      end
    end
    rx = stop_bit;
    #(bit_ns * 1ns);
    rx = 1'b1;
  endtask

  initial begin
    #100ns;
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(ferr), 32'h0);
    check("reset_overrun", 32'(ovr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(20);
    check("idle_after_reset", 32'(rx_cnt), 32'd0);

    // Basic bytes.
    @(negedge clk);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, BitNs, -1);
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, BitNs, -1);
    idle_bits(2);
    check("basic_count", 32'(rx_cnt), 32'd2);
    check("basic_no_ferr", 32'(ferr_cnt), 32'd0);
    check("basic_no_ovr", 32'(ovr_cnt), 32'd0);

    // False start, then a glitched bit recovered by majority vote.
    @(negedge clk);
    rx = 1'b0;
    #380ns;
    rx = 1'b1;
    idle_bits(12);
    check("false_start", 32'(rx_cnt), 32'd2);
    @(negedge clk);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BitNs, 3);
    idle_bits(2);
    check("glitch_count", 32'(rx_cnt), 32'd3);

    // Framing error, then break followed by a good byte.
    @(negedge clk);
    send_frame(8'h3C, 1'b0, BitNs, -1);
    idle_bits(2);
    check("ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("ferr_no_byte", 32'(rx_cnt), 32'd3);
    check("ferr_valid_low", 32'(valid), 32'h0);
    @(negedge clk);
    rx = 1'b0;
    #(20.0 * BitNs * 1ns);
    idle_bits(1);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, BitNs, -1);
    idle_bits(2);
    check("break_ferr", 32'(ferr_cnt), 32'd2);
    check("break_count", 32'(rx_cnt), 32'd4);

    // Overrun with the consumer stalled.
    @(negedge clk);
    ready = 1'b0;
    send_frame(8'h11, 1'b1, BitNs, -1);
    send_frame(8'h22, 1'b1, BitNs, -1);
    idle_bits(2);
    check("ovr_pulse", 32'(ovr_cnt), 32'd1);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_data_held", 32'(data), 32'h11);
    @(negedge clk);
    exp_q.push_back(8'h11);
    ready = 1'b1;
    idle_bits(1);
    check("ovr_drain", 32'(rx_cnt), 32'd5);
    check("ovr_valid_cleared", 32'(valid), 32'h0);

    // +3% and -3% line rate, back-to-back.
    @(negedge clk);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send_frame(8'hF0, 1'b1, BitNs / 1.03, -1);
    send_frame(8'h0F, 1'b1, BitNs / 1.03, -1);
    idle_bits(2);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send_frame(8'hF0, 1'b1, BitNs / 0.97, -1);
    send_frame(8'h0F, 1'b1, BitNs / 0.97, -1);
    idle_bits(2);
    check("final_count", 32'(rx_cnt), 32'd9);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_ferr", 32'(ferr_cnt), 32'd2);
    check("final_ovr", 32'(ovr_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
